// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR envelope generator with shared-multiplier handshake.
// Optional `define ENV_EXP_DECAY_EN selects piecewise-exponential decay/release.
module adsr_envelope #(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned ACC_W      = 24
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       env_start_i,
    input  logic [1:0] voice_idx_i,
    input  logic       gate_i,
    input  logic [3:0] attack_i,
    input  logic [3:0] decay_i,
    input  logic [3:0] sustain_i,
    input  logic [3:0] release_i,
    input  logic       mult_ready_i,
    output logic       mult_start_o,
    output logic [7:0] env_o,
    output logic       env_ready_o,
    output logic       env_busy_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_MWAIT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] PH_ATTACK  = 2'd0;
    localparam logic [1:0] PH_DECAY   = 2'd1;
    localparam logic [1:0] PH_SUSTAIN = 2'd2;
    localparam logic [1:0] PH_RELEASE = 2'd3;

    function automatic logic [17:0] inc_a(input logic [3:0] r);
        logic [17:0] v;
        case (r)
            4'd0:    v = 18'd167117;
            4'd1:    v = 18'd41779;
            4'd2:    v = 18'd20890;
            4'd3:    v = 18'd13926;
            4'd4:    v = 18'd8796;
            4'd5:    v = 18'd5968;
            4'd6:    v = 18'd4915;
            4'd7:    v = 18'd4178;
            4'd8:    v = 18'd3342;
            4'd9:    v = 18'd1337;
            4'd10:   v = 18'd668;
            4'd11:   v = 18'd418;
            4'd12:   v = 18'd334;
            4'd13:   v = 18'd111;
            4'd14:   v = 18'd67;
            default: v = 18'd42;
        endcase
        return v;
    endfunction

    // Attack increment divided by three, rounded down.
    function automatic logic [17:0] inc_dr(input logic [3:0] r);
        logic [17:0] v;
        case (r)
            4'd0:    v = 18'd55705;
            4'd1:    v = 18'd13926;
            4'd2:    v = 18'd6963;
            4'd3:    v = 18'd4642;
            4'd4:    v = 18'd2932;
            4'd5:    v = 18'd1989;
            4'd6:    v = 18'd1638;
            4'd7:    v = 18'd1392;
            4'd8:    v = 18'd1114;
            4'd9:    v = 18'd445;
            4'd10:   v = 18'd222;
            4'd11:   v = 18'd139;
            4'd12:   v = 18'd111;
            4'd13:   v = 18'd37;
            4'd14:   v = 18'd22;
            default: v = 18'd14;
        endcase
        return v;
    endfunction

    logic [2:0]       r_state;
    logic [1:0]       r_idx;
    logic             r_gate;
    logic [3:0]       r_att;
    logic [3:0]       r_dec;
    logic [3:0]       r_sus;
    logic [3:0]       r_rel;
    logic [1:0]       r_phase;
    logic [ACC_W-1:0] r_acc;
    logic             r_gprev;
    logic [1:0]       r_nphase;
    logic [ACC_W-1:0] r_nacc;
    logic [7:0]       r_env;
    logic             r_mstart;
    logic             r_eready;
    logic             r_busy;

    logic [1:0]       r_v_phase [NUM_VOICES];
    logic [ACC_W-1:0] r_v_acc   [NUM_VOICES];
    logic             r_v_gprev [NUM_VOICES];

    logic             w_valid;
    logic [1:0]       w_rd_phase;
    logic [ACC_W-1:0] w_rd_acc;
    logic             w_rd_gprev;
    logic [1:0]       w_gphase;
    logic [1:0]       w_nphase;
    logic [ACC_W-1:0] w_nacc;
    logic [ACC_W-1:0] w_sus;
    logic [17:0]      w_step;
    logic [2:0]       w_sh;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W:0]   w_dif;

    assign w_valid = (32'(r_idx) < NUM_VOICES);
    assign w_sus   = {r_sus, r_sus, {(ACC_W-8){1'b0}}};

    always_comb begin
        w_rd_phase = PH_RELEASE;
        w_rd_acc   = '0;
        w_rd_gprev = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (32'(r_idx) == 32'(i)) begin
                w_rd_phase = r_v_phase[i];
                w_rd_acc   = r_v_acc[i];
                w_rd_gprev = r_v_gprev[i];
            end
        end
    end

`ifdef ENV_EXP_DECAY_EN
    logic [7:0] w_lvl;
    assign w_lvl = r_acc[ACC_W-1 -: 8];

    always_comb begin
        if (w_lvl >= 8'h5D)      w_sh = 3'd0;
        else if (w_lvl >= 8'h36) w_sh = 3'd1;
        else if (w_lvl >= 8'h1A) w_sh = 3'd2;
        else if (w_lvl >= 8'h0E) w_sh = 3'd3;
        else if (w_lvl >= 8'h06) w_sh = 3'd4;
        else                     w_sh = 3'd5;
    end
`else
    assign w_sh = 3'd0;
`endif

    // Gate edges override the stored phase before the rate step is applied.
    always_comb begin
        w_gphase = r_phase;
        if (r_gate && !r_gprev)
            w_gphase = PH_ATTACK;
        else if (!r_gate && r_gprev)
            w_gphase = PH_RELEASE;
    end

    assign w_step = inc_dr((w_gphase == PH_RELEASE) ? r_rel : r_dec) >> w_sh;
    assign w_sum  = {1'b0, r_acc} + (ACC_W+1)'(inc_a(r_att));
    assign w_dif  = {1'b0, r_acc} - (ACC_W+1)'(w_step);

    always_comb begin
        w_nacc   = r_acc;
        w_nphase = w_gphase;
        unique case (w_gphase)
            PH_ATTACK: begin
                if (w_sum[ACC_W]) begin
                    w_nacc   = '1;
                    w_nphase = PH_DECAY;
                end else begin
                    w_nacc = w_sum[ACC_W-1:0];
                end
            end
            PH_DECAY: begin
                if (w_dif[ACC_W] || (w_dif[ACC_W-1:0] <= w_sus)) begin
                    w_nacc   = w_sus;
                    w_nphase = PH_SUSTAIN;
                end else begin
                    w_nacc = w_dif[ACC_W-1:0];
                end
            end
            PH_SUSTAIN: begin
                if (r_acc > w_sus)
                    w_nphase = PH_DECAY;
            end
            default: begin
                w_nacc = w_dif[ACC_W] ? '0 : w_dif[ACC_W-1:0];
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_gate   <= 1'b0;
            r_att    <= 4'd0;
            r_dec    <= 4'd0;
            r_sus    <= 4'd0;
            r_rel    <= 4'd0;
            r_phase  <= PH_RELEASE;
            r_acc    <= '0;
            r_gprev  <= 1'b0;
            r_nphase <= PH_RELEASE;
            r_nacc   <= '0;
            r_env    <= 8'd0;
            r_mstart <= 1'b0;
            r_eready <= 1'b0;
            r_busy   <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_v_phase[i] <= PH_RELEASE;
                r_v_acc[i]   <= '0;
                r_v_gprev[i] <= 1'b0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (env_start_i) begin
                        r_idx   <= voice_idx_i;
                        r_gate  <= gate_i;
                        r_att   <= attack_i;
                        r_dec   <= decay_i;
                        r_sus   <= sustain_i;
                        r_rel   <= release_i;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_phase <= w_rd_phase;
                    r_acc   <= w_rd_acc;
                    r_gprev <= w_rd_gprev;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_nacc   <= w_nacc;
                    r_nphase <= w_nphase;
                    r_env    <= w_valid ? w_nacc[ACC_W-1 -: 8] : 8'd0;
                    r_mstart <= 1'b1;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    r_mstart <= 1'b0;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (32'(r_idx) == 32'(i)) begin
                            r_v_phase[i] <= r_nphase;
                            r_v_acc[i]   <= r_nacc;
                            r_v_gprev[i] <= r_gate;
                        end
                    end
                    r_state <= S_MWAIT;
                end
                S_MWAIT: begin
                    if (mult_ready_i) begin
                        r_eready <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_eready <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mult_start_o = r_mstart;
    assign env_o        = r_env;
    assign env_ready_o  = r_eready;
    assign env_busy_o   = r_busy;

endmodule
